// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream: credit-gated drain of a synchronous FIFO into a 2-entry skid buffer, re-presented as valid/ready.
// Define BEAT_CNT_EN to add the saturating beat_cnt output; define SIM to enable the internal overflow assertion.
module fifo_rd_stream #(
  parameter int FIFO_WIDTH = 16,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fifo_empty,
  input  logic [FIFO_WIDTH-1:0] fifo_data_out,
  input  logic                  fifo_underflow,
  output logic                  fifo_rd_en,
  output logic                  m_valid,
  output logic [FIFO_WIDTH-1:0] m_data,
  input  logic                  m_ready,
  output logic                  rd_err
`ifdef BEAT_CNT_EN
  ,
  output logic [CNT_WIDTH-1:0]  beat_cnt
`endif
);

  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} occ_e;

  occ_e                       occ, occ_nxt;
  logic                       rd_v_q;
  logic                       pop, cap;
  logic [2:0]                 credit;
  logic [1:0][FIFO_WIDTH-1:0] mem;
  logic                       hd, tl;

  assign pop = m_valid & m_ready;
  assign cap = rd_v_q;

  // Slots committed after this edge: held beats plus the one in flight, minus the one leaving.
  assign credit     = {1'b0, occ} + {2'b00, rd_v_q} - {2'b00, pop};
  assign fifo_rd_en = !rst & !fifo_empty & (credit < 3'd2);

  always_comb begin
    occ_nxt = occ;
    case (occ)
      EMPTY:   if (cap) occ_nxt = ONE;
      ONE: begin
        if (cap && !pop)      occ_nxt = TWO;
        else if (!cap && pop) occ_nxt = EMPTY;
      end
      TWO:     if (pop && !cap) occ_nxt = ONE;
      default: occ_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      occ    <= EMPTY;
      rd_v_q <= 1'b0;
      hd     <= 1'b0;
      tl     <= 1'b0;
      mem    <= '0;
      rd_err <= 1'b0;
    end else begin
      occ    <= occ_nxt;
      rd_v_q <= fifo_rd_en;
      if (cap) begin
        mem[tl] <= fifo_data_out;
        tl      <= ~tl;
      end
      if (pop) hd <= ~hd;
      rd_err <= rd_err | fifo_underflow;
    end
  end

  // hd == tl whenever the buffer is empty, so a fresh capture lands directly at the head.
  assign m_valid = (occ != EMPTY);
  assign m_data  = mem[hd];

`ifdef BEAT_CNT_EN
  always_ff @(posedge clk) begin
    if (rst)                           beat_cnt <= '0;
    else if (pop && (beat_cnt != '1))  beat_cnt <= beat_cnt + 1'b1;
  end
`else
  logic unused_cnt_cfg;
  assign unused_cnt_cfg = ^CNT_WIDTH;
`endif

`ifdef SIM
  always_ff @(posedge clk) begin
    if (!rst) assert (!(occ == TWO && cap)) else $error("capture into full skid buffer");
  end
`endif

endmodule
